tlp_tx_buffer: RTL

- Store-and-forward transmit buffer for 64-bit Avalon-ST TLP streams.
- Sits between the TLP generators (completer, DMA requester) and the PCIe hard-IP TX port.
- Collects whole TLPs and only releases a packet once its EOP word is stored, so the hard IP sees no mid-packet valid bubbles.
- Packets longer than the buffer fall back to cut-through so they cannot deadlock.

---
 rtl/tlp_tx_pkg.sv | 33 +++
 rtl/sync_fifo_la.sv | 56 +++++
 rtl/tlp_tx_buffer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/tlp_tx_pkg.sv
// Shared encodings for the TLP transmit buffer: FIFO word layout, output FSM
// states and input framing-tracker states.
package tlp_tx_pkg;

    // Flag bits sit directly above the data field of each stored word.
    localparam int OFS_EOP   = 0;
    localparam int OFS_SOP   = 1;
    localparam int OFS_EMPTY = 2;
    localparam int FLAG_BITS = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } out_state_e;

    typedef enum logic {
        TRK_OUT_PKT = 1'b0,
        TRK_IN_PKT  = 1'b1
    } trk_state_e;

    function automatic int fld_eop(input int data_w);
        return data_w + OFS_EOP;
    endfunction

    function automatic int fld_sop(input int data_w);
        return data_w + OFS_SOP;
    endfunction

    function automatic int fld_empty(input int data_w);
        return data_w + OFS_EMPTY;
    endfunction

endpackage

// File: rtl/sync_fifo_la.sv
// Look-ahead synchronous FIFO: the head word is always visible on ov_RdData,
// so a pop simply advances to the next word.
module sync_fifo_la #(
    parameter int pWIDTH = 67,
    parameter int pDEPTH = 64
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst,
    input  logic                       i_Wr,
    input  logic [pWIDTH-1:0]          iv_WrData,
    input  logic                       i_Rd,
    output logic [pWIDTH-1:0]          ov_RdData,
    output logic                       o_Full,
    output logic                       o_Empty,
    output logic [$clog2(pDEPTH):0]    ov_Used
);
    localparam int AW = $clog2(pDEPTH);
    localparam logic [AW:0] USED_FULL = (AW+1)'(pDEPTH);

    logic [pWIDTH-1:0] mem_q [pDEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       used_q;
    logic              wr_ok;
    logic              rd_ok;

    assign wr_ok = i_Wr & ~o_Full;
    assign rd_ok = i_Rd & ~o_Empty;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   used_q <= used_q + (AW+1)'(1);
                2'b01:   used_q <= used_q - (AW+1)'(1);
                default: used_q <= used_q;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge i_Clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= iv_WrData;
    end

    assign ov_RdData = mem_q[rd_ptr_q];
    assign o_Full    = (used_q == USED_FULL);
    assign o_Empty   = (used_q == '0);
    assign ov_Used   = used_q;

endmodule

// File: rtl/tlp_tx_buffer.sv
// Store-and-forward TX buffer for Avalon-ST TLPs in front of the PCIe hard IP;
// a packet larger than the buffer is streamed out in cut-through mode.
//
// state   | meaning
// ST_IDLE | between packets; waits for a complete packet or a full FIFO
// ST_SEND | presenting one packet to the hard IP until its EOP is read
module tlp_tx_buffer
    import tlp_tx_pkg::*;
#(
    parameter int pWIDTH = 64,
    parameter int pDEPTH = 64
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Flush,
    input  logic              i_InTxDv,
    input  logic              i_InTxSop,
    input  logic              i_InTxEop,
    input  logic              i_InTxEmpty,
    input  logic [pWIDTH-1:0] iv_InTxData,
    output logic              o_InTxReady,
    output logic              o_OutTxDv,
    output logic              o_OutTxSop,
    output logic              o_OutTxEop,
    output logic              o_OutTxEmpty,
    output logic [pWIDTH-1:0] ov_OutTxData,
    input  logic              i_OutTxReady,
    output logic [7:0]        o8_PktCnt,
    output logic              o_FrameErr,
    output logic              o_CutThru
);
    localparam int FW      = pWIDTH + FLAG_BITS;
    localparam int AW      = $clog2(pDEPTH);
    localparam int B_EOP   = fld_eop(pWIDTH);
    localparam int B_SOP   = fld_sop(pWIDTH);
    localparam int B_EMPTY = fld_empty(pWIDTH);
    localparam logic [AW:0] USED_FULL = (AW+1)'(pDEPTH);

    trk_state_e trk_q, trk_d;
    out_state_e state_q, state_d;
    logic       ferr_q, ferr_d;
    logic       cut_q, cut_d;
    logic       rdy_q, rdy_d;
    logic [7:0] pkt_cnt_q, pkt_cnt_d;

    logic          in_acc;
    logic          out_dv;
    logic          fifo_clr;
    logic          fifo_wr;
    logic          fifo_rd;
    logic [FW-1:0] fifo_wdata;
    logic [FW-1:0] fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_used;
    logic [AW:0]   used_nxt;
    logic          rd_eop;

    assign fifo_clr   = i_Rst | i_Flush;
    assign in_acc     = i_InTxDv & rdy_q;
    assign fifo_wdata = {i_InTxEmpty, i_InTxSop, i_InTxEop, iv_InTxData};
    assign rd_eop     = fifo_rdata[B_EOP];
    assign fifo_rd    = out_dv & i_OutTxReady;

    sync_fifo_la #(
        .pWIDTH (FW),
        .pDEPTH (pDEPTH)
    ) u_fifo (
        .i_Clk     (i_Clk),
        .i_Rst     (fifo_clr),
        .i_Wr      (fifo_wr),
        .iv_WrData (fifo_wdata),
        .i_Rd      (fifo_rd),
        .ov_RdData (fifo_rdata),
        .o_Full    (fifo_full),
        .o_Empty   (fifo_empty),
        .ov_Used   (fifo_used)
    );

    // Orphan words outside a packet are dropped; a SOP inside a packet restarts it.
    always_comb begin
        trk_d   = trk_q;
        ferr_d  = ferr_q;
        fifo_wr = 1'b0;
        if (in_acc) begin
            if (trk_q == TRK_OUT_PKT && !i_InTxSop) begin
                ferr_d = 1'b1;
            end else begin
                fifo_wr = 1'b1;
                if (trk_q == TRK_IN_PKT && i_InTxSop) ferr_d = 1'b1;
                trk_d = i_InTxEop ? TRK_OUT_PKT : TRK_IN_PKT;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cut_d   = cut_q;
        out_dv  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pkt_cnt_q != 8'd0) begin
                    state_d = ST_SEND;
                end else if (fifo_full) begin
                    state_d = ST_SEND;
                    cut_d   = 1'b1;
                end
            end
            ST_SEND: begin
                out_dv = ~fifo_empty;
                if (out_dv && i_OutTxReady && rd_eop) begin
                    state_d = ST_IDLE;
                    cut_d   = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        case ({fifo_wr & i_InTxEop, fifo_rd & rd_eop})
            2'b10:   if (pkt_cnt_q != 8'hFF) pkt_cnt_d = pkt_cnt_q + 8'd1;
            2'b01:   if (pkt_cnt_q != 8'h00) pkt_cnt_d = pkt_cnt_q - 8'd1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    // Ready looks at next cycle's occupancy so a registered ready never overfills.
    assign used_nxt = fifo_used + (AW+1)'(fifo_wr) - (AW+1)'(fifo_rd);
    assign rdy_d    = (used_nxt != USED_FULL);

    always_ff @(posedge i_Clk) begin
        if (fifo_clr) begin
            trk_q     <= TRK_OUT_PKT;
            state_q   <= ST_IDLE;
            cut_q     <= 1'b0;
            rdy_q     <= 1'b0;
            pkt_cnt_q <= 8'd0;
        end else begin
            trk_q     <= trk_d;
            state_q   <= state_d;
            cut_q     <= cut_d;
            rdy_q     <= rdy_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst)         ferr_q <= 1'b0;
        else if (!i_Flush) ferr_q <= ferr_d;
    end

    assign o_InTxReady  = rdy_q;
    assign o_OutTxDv    = out_dv;
    assign o_OutTxSop   = out_dv & fifo_rdata[B_SOP];
    assign o_OutTxEop   = out_dv & rd_eop;
    assign o_OutTxEmpty = out_dv & fifo_rdata[B_EMPTY];
    assign ov_OutTxData = out_dv ? fifo_rdata[pWIDTH-1:0] : '0;
    assign o8_PktCnt    = pkt_cnt_q;
    assign o_FrameErr   = ferr_q;
    assign o_CutThru    = cut_q;

endmodule
